sha2_digest_uart_tx: RTL and testbench

- Host-facing return path of the SHA-2 controller. It serialises a completed digest onto the board UART TX line as 8N1 frames.
- Complements the controller's RX command path: RX carries message bytes in, this block carries the hash bytes out.
- Sits between the SHA-2 core's digest register and the TX pin. It is a pure sequential transmitter with a start/busy/done handshake.

---
 rtl/sha2_digest_uart_tx.sv | 129 ++++++++++++
 tb/tb_sha2_digest_uart_tx.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sha2_digest_uart_tx.sv
// SHA-2 digest return path: shifts a latched digest out of the UART TX pin
// as 8N1 frames, most-significant byte first, LSB of each byte first.
module sha2_digest_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DIGEST_BYTES = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [8*DIGEST_BYTES-1:0] digest,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      tx
);

    localparam int DW  = 8 * DIGEST_BYTES;
    localparam int BCW = $clog2(CLKS_PER_BIT);
    localparam int BYW = (DIGEST_BYTES > 1) ? $clog2(DIGEST_BYTES) : 1;
    localparam logic [BCW-1:0] BAUD_MAX  = BCW'(CLKS_PER_BIT - 1);
    localparam logic [BYW-1:0] BYTE_LAST = BYW'(DIGEST_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        STOP_BIT
    } state_t;

    state_t         state, state_d;
    logic [BCW-1:0] baud, baud_d;
    logic [2:0]     bit_idx, bit_d;
    logic [BYW-1:0] byte_idx, byte_d;
    logic [DW-1:0]  shreg, sh_d;
    logic [7:0]     cur_byte;
    logic           baud_end;
    logic           tx_d, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud     <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
            done     <= 1'b0;
        end else begin
            state    <= state_d;
            baud     <= baud_d;
            bit_idx  <= bit_d;
            byte_idx <= byte_d;
            shreg    <= sh_d;
            tx       <= tx_d;
            done     <= done_d;
        end
    end

    assign busy     = (state != IDLE);
    assign baud_end = (baud == BAUD_MAX);
    // The byte on the wire always sits in the top 8 bits of the shifter.
    assign cur_byte = sh_d[DW-1 -: 8];

    always_comb begin
        state_d = state;
        baud_d  = baud;
        bit_d   = bit_idx;
        byte_d  = byte_idx;
        sh_d    = shreg;
        done_d  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_d = START_BIT;
                    sh_d    = digest;
                    byte_d  = '0;
                    baud_d  = '0;
                end
            end
            START_BIT: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA_BITS;
                end else begin
                    baud_d = baud + 1'b1;
                end
            end
            DATA_BITS: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_idx == 3'd7) begin
                        state_d = STOP_BIT;
                    end else begin
                        bit_d = bit_idx + 3'd1;
                    end
                end else begin
                    baud_d = baud + 1'b1;
                end
            end
            STOP_BIT: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (byte_idx == BYTE_LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        byte_d  = byte_idx + 1'b1;
                        sh_d    = shreg << 8;
                        state_d = START_BIT;
                    end
                end else begin
                    baud_d = baud + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // tx is registered from the next-state view so the pin never glitches.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            START_BIT: tx_d = 1'b0;
            DATA_BITS: tx_d = cur_byte[bit_d];
            default:   tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_sha2_digest_uart_tx.sv
// Bench for sha2_digest_uart_tx: UART receivers pop an expected-byte
// scoreboard; handshake timing is checked against cycle counts.
module tb_sha2_digest_uart_tx;

    localparam int CA = 4;
    localparam int DA = 2;
    localparam int CB = 3;
    localparam int DB = 32;
    localparam logic [255:0] ABC =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [15:0]  dig_a = '0;
    logic         start_a = 1'b0;
    logic         busy_a, done_a, tx_a;
    logic [255:0] dig_b = '0;
    logic         start_b = 1'b0;
    logic         busy_b, done_b, tx_b;

    logic [7:0] expq_a[$];
    logic [7:0] expq_b[$];
    int total = 0;
    int passed = 0;
    int done_cnt_a = 0;
    int done_cnt_b = 0;

    sha2_digest_uart_tx #(.CLKS_PER_BIT(CA), .DIGEST_BYTES(DA)) u_dut_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .digest (dig_a),
        .start  (start_a),
        .busy   (busy_a),
        .done   (done_a),
        .tx     (tx_a)
    );

    sha2_digest_uart_tx #(.CLKS_PER_BIT(CB), .DIGEST_BYTES(DB)) u_dut_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .digest (dig_b),
        .start  (start_b),
        .busy   (busy_b),
        .done   (done_b),
        .tx     (tx_b)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done_a) done_cnt_a <= done_cnt_a + 1;
        if (done_b) done_cnt_b <= done_cnt_b + 1;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            passed++;
    endtask

    function automatic logic line(input int sel);
        return (sel == 0) ? tx_a : tx_b;
    endfunction

    // Bench UART receiver; samples one cycle into each bit.
    task automatic rx_loop(input int sel, input int c);
        logic [7:0] b;
        bit ab;
        forever begin
            @(negedge clk);
            if (rst_n && line(sel) == 1'b0) begin
                ab = 0;
                b  = '0;
                @(negedge clk);
                if (!rst_n) continue;
                check(sel ? "start_bit_b" : "start_bit_a", line(sel), 0);
                for (int i = 0; i < 8; i++) begin
                    repeat (c) @(negedge clk);
                    if (!rst_n) begin
                        ab = 1;
                        break;
                    end
                    b[i] = line(sel);
                end
                if (ab) continue;
                repeat (c) @(negedge clk);
                if (!rst_n) continue;
                check(sel ? "stop_bit_b" : "stop_bit_a", line(sel), 1);
                if (sel == 0) begin
                    if (expq_a.size() == 0) check("rx_a_unexpected", b, 9'h100);
                    else check("rx_a_byte", b, expq_a.pop_front());
                end else begin
                    if (expq_b.size() == 0) check("rx_b_unexpected", b, 9'h100);
                    else check("rx_b_byte", b, expq_b.pop_front());
                end
                repeat (c - 2) @(negedge clk);
            end
        end
    endtask

    initial rx_loop(0, CA);
    initial rx_loop(1, CB);

    task automatic wait_done(input int sel, input int lim, output int n);
        n = 0;
        while (!(sel ? done_b : done_a) && n < lim) begin
            @(negedge clk);
            n++;
        end
        check(sel ? "done_b_seen" : "done_a_seen", sel ? done_b : done_a, 1);
    endtask

    task automatic run_a(input logic [15:0] d);
        @(negedge clk);
        dig_a   = d;
        start_a = 1'b1;
        expq_a.push_back(d[15:8]);
        expq_a.push_back(d[7:0]);
        @(negedge clk);
        start_a = 1'b0;
        check("lat_tx", tx_a, 0);
        check("lat_busy", busy_a, 1);
    endtask

    initial begin
        int n;
        int bad;
        int base;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            check("rst_state", {tx_a, busy_a, done_a, tx_b, busy_b, done_b}, 6'b100100);
        end
        rst_n = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if ({tx_a, busy_a, done_a, tx_b, busy_b, done_b} !== 6'b100100) bad++;
        end
        check("idle_bad_cycles", bad, 0);

        base = done_cnt_a;
        run_a(16'hA53C);
        wait_done(0, 200, n);
        check("frame_time", n, 80);
        check("busy_at_done", busy_a, 0);
        @(negedge clk);
        check("done_one_cycle", done_a, 0);
        repeat (5) @(negedge clk);
        check("single_done_cnt", done_cnt_a - base, 1);
        check("single_q_empty", expq_a.size(), 0);

        base = done_cnt_a;
        run_a(16'hA53C);
        repeat (30) @(negedge clk);
        dig_a   = 16'hFFFF;
        start_a = 1'b1;
        repeat (10) @(negedge clk);
        start_a = 1'b0;
        wait_done(0, 200, n);
        check("ign_time", n, 40);
        repeat (20) @(negedge clk);
        check("ign_no_restart", busy_a, 0);
        check("ign_done_cnt", done_cnt_a - base, 1);
        check("ign_q_empty", expq_a.size(), 0);

        base = done_cnt_a;
        @(negedge clk);
        dig_a   = 16'hA53C;
        start_a = 1'b1;
        repeat (2) begin
            expq_a.push_back(8'hA5);
            expq_a.push_back(8'h3C);
        end
        @(negedge clk);
        wait_done(0, 200, n);
        check("b2b_first", n, 80);
        check("b2b_idle_tx", tx_a, 1);
        @(negedge clk);
        check("b2b_restart_tx", tx_a, 0);
        check("b2b_restart_busy", busy_a, 1);
        wait_done(0, 200, n);
        start_a = 1'b0;
        check("b2b_period", n + 1, 81);
        repeat (5) @(negedge clk);
        check("b2b_stop", busy_a, 0);
        check("b2b_done_cnt", done_cnt_a - base, 2);
        check("b2b_q_empty", expq_a.size(), 0);

        base = done_cnt_a;
        run_a(16'hA53C);
        repeat (10) @(negedge clk);
        check("pre_rst_busy", busy_a, 1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_tx", tx_a, 1);
        check("async_rst_busy", busy_a, 0);
        expq_a.delete();
        repeat (6) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_no_done", done_cnt_a - base, 0);
        run_a(16'hA53C);
        wait_done(0, 200, n);
        check("post_rst_time", n, 80);
        repeat (5) @(negedge clk);
        check("post_rst_q_empty", expq_a.size(), 0);

        base = done_cnt_b;
        @(negedge clk);
        dig_b   = ABC;
        start_b = 1'b1;
        for (int k = 0; k < DB; k++) expq_b.push_back(ABC[8*(DB-k)-1 -: 8]);
        @(negedge clk);
        start_b = 1'b0;
        dig_b   = '0;
        wait_done(1, 2000, n);
        check("abc_time", n, 10 * CB * DB);
        repeat (5) @(negedge clk);
        check("abc_done_cnt", done_cnt_b - base, 1);
        check("abc_q_empty", expq_b.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
